fb_id_ctrl: RTL and testbench



---
 rtl/fb_id_ctrl_pkg.sv | 76 +++++++
 rtl/fb_imm_gen.sv | 28 ++
 rtl/fb_id_ctrl.sv | 130 +++++++++++++
 tb/tb_fb_id_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_id_ctrl_pkg.sv
// Shared constants, types and decode helpers for the Firebird ID stage.
package fb_id_ctrl_pkg;

  localparam int unsigned FB_32BITS = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned OPC_W     = 7;

  // Major opcodes used by hazard qualification and immediate selection
  localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_S     = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_B     = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_IMM   = 7'b0010011;

  // addi x0,x0,0
  localparam logic [FB_32BITS-1:0] FB_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ID_EMPTY = 2'd0,
    ID_FULL  = 2'd1,
    ID_STALL = 2'd2
  } id_state_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Register-field view of an instruction word
  typedef struct packed {
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rd;
  } id_regs_t;

  // rs1 is read by everything except U-type and JAL
  function automatic logic uses_rs1(input logic [OPC_W-1:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  // rs2 is read only by register-register, store and branch forms
  function automatic logic uses_rs2(input logic [OPC_W-1:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_B);
  endfunction

  // Immediate format of an opcode; unknown opcodes fall back to I-type
  function automatic imm_fmt_e imm_fmt(input logic [OPC_W-1:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_R:              fmt = IMM_NONE;
      OP_S:              fmt = IMM_S;
      OP_B:              fmt = IMM_B;
      OP_LUI, OP_AUIPC:  fmt = IMM_U;
      OP_JAL:            fmt = IMM_J;
      default:           fmt = IMM_I;
    endcase
    return fmt;
  endfunction

  function automatic id_regs_t reg_fields(input logic [FB_32BITS-1:0] inst);
    id_regs_t r;
    r.rs2 = inst[24:20];
    r.rs1 = inst[19:15];
    r.rd  = inst[11:7];
    return r;
  endfunction

endpackage

// File: rtl/fb_imm_gen.sv
// Combinational immediate generator for the instruction held in ID.
module fb_imm_gen
  import fb_id_ctrl_pkg::*;
(
  input  logic [FB_32BITS-1:0] i_inst,
  output logic [FB_32BITS-1:0] o_imm
);

  imm_fmt_e w_fmt;

  assign w_fmt = imm_fmt(i_inst[OPC_W-1:0]);

  // Reassemble and sign-extend the immediate for the decoded format
  always_comb begin
    o_imm = '0;
    case (w_fmt)
      IMM_I:   o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_S:   o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_B:   o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                        i_inst[30:25], i_inst[11:8], 1'b0};
      IMM_U:   o_imm = {i_inst[31:12], 12'b0};
      IMM_J:   o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                        i_inst[20], i_inst[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/fb_id_ctrl.sv
// Firebird ID stage controller: IF/ID register, handshakes, load-use stall, flush.
module fb_id_ctrl
  import fb_id_ctrl_pkg::*;
#(
  parameter int unsigned           CNT_W    = 16,
  parameter logic [FB_32BITS-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [FB_32BITS-1:0] if_inst,
  input  logic [FB_32BITS-1:0] if_pc,
  input  logic                 ex_ready,
  input  logic                 ex_is_load,
  input  logic [REG_W-1:0]     ex_rd,
  input  logic                 ex_redirect,
  output logic                 id_valid,
  output logic [FB_32BITS-1:0] id_inst,
  output logic [FB_32BITS-1:0] id_pc,
  output logic [FB_32BITS-1:0] id_imm,
  output logic [REG_W-1:0]     id_rs1,
  output logic [REG_W-1:0]     id_rs2,
  output logic [REG_W-1:0]     id_rd,
  output logic [CNT_W-1:0]     stall_cnt
);

  id_state_e            r_state;
  id_state_e            w_state_nxt;
  logic [FB_32BITS-1:0] r_inst;
  logic [FB_32BITS-1:0] r_pc;
  logic [CNT_W-1:0]     r_cnt;

  id_regs_t             w_regs;
  logic [OPC_W-1:0]     w_opcode;
  logic                 w_use_rs1;
  logic                 w_use_rs2;
  logic                 w_hazard;
  logic                 w_id_valid;
  logic                 w_issue;
  logic                 w_if_ready;
  logic                 w_accept;
  logic                 w_cnt_inc;

  assign w_regs    = reg_fields(r_inst);
  assign w_opcode  = r_inst[OPC_W-1:0];
  assign w_use_rs1 = uses_rs1(w_opcode);
  assign w_use_rs2 = uses_rs2(w_opcode);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ID_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: redirect beats accept beats issue beats hazard
  always_comb begin
    w_state_nxt = r_state;
    if (ex_redirect) begin
      w_state_nxt = ID_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = ID_FULL;
    end else if (w_issue) begin
      w_state_nxt = ID_EMPTY;
    end else if (w_hazard) begin
      w_state_nxt = ID_STALL;
    end else if (r_state == ID_STALL) begin
      w_state_nxt = ID_FULL;
    end
  end

  // Handshake and hazard outputs; IF may refill in the same cycle ID issues
  always_comb begin
    w_hazard   = 1'b0;
    w_id_valid = 1'b0;
    w_issue    = 1'b0;
    w_if_ready = 1'b0;
    w_accept   = 1'b0;
    w_cnt_inc  = 1'b0;

    if ((r_state != ID_EMPTY) && ex_is_load && (ex_rd != '0)) begin
      w_hazard = (w_use_rs1 && (ex_rd == w_regs.rs1)) ||
                 (w_use_rs2 && (ex_rd == w_regs.rs2));
    end
    w_id_valid = (r_state != ID_EMPTY) && !w_hazard && !ex_redirect;
    w_issue    = w_id_valid && ex_ready;
    w_if_ready = !ex_redirect && ((r_state == ID_EMPTY) || w_issue);
    w_accept   = if_valid && w_if_ready;
    // A redirect squashes the stalled instruction, so that cycle is not a stall
    w_cnt_inc  = w_hazard && !ex_redirect;
  end

  // IF/ID payload register, loaded only on accept so back-pressure holds it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst <= FB_NOP;
      r_pc   <= RESET_PC;
    end else if (w_accept) begin
      r_inst <= if_inst;
      r_pc   <= if_pc;
    end
  end

  // Saturating hazard-stall cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  fb_imm_gen u_imm_gen (
    .i_inst (r_inst),
    .o_imm  (id_imm)
  );

  assign if_ready  = w_if_ready;
  assign id_valid  = w_id_valid;
  assign id_inst   = r_inst;
  assign id_pc     = r_pc;
  assign id_rs1    = w_regs.rs1;
  assign id_rs2    = w_regs.rs2;
  assign id_rd     = w_regs.rd;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_fb_id_ctrl.sv
// Self-checking bench for fb_id_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model of the ID slot.
module tb_fb_id_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_SW   = 32'h0011_2423;  // sw x1,8(x2)
  localparam logic [31:0] I_ADD  = 32'h0020_81B3;  // add x3,x1,x2
  localparam logic [31:0] I_LUI  = 32'h0000_80B7;  // lui x1,0x8 (rs1 field = 1)
  localparam logic [31:0] I_BEQ  = 32'hFE00_0EE3;  // beq x0,x0,-4
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        ex_ready;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_redirect;

  logic        if_ready, id_valid;
  logic [31:0] id_inst, id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [15:0] stall_cnt;

  logic        s_if_ready, s_id_valid;
  logic [31:0] s_id_inst, s_id_pc, s_id_imm;
  logic [4:0]  s_id_rs1, s_id_rs2, s_id_rd;
  logic [2:0]  s_stall_cnt;

  // Model of the ID slot: is something held, what, and total stall cycles
  bit          m_occ;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  int          m_cnt;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  fb_id_ctrl #(.CNT_W(16), .RESET_PC(RST_PC)) u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing the stimulus, to exercise saturation
  fb_id_ctrl #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(s_if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .id_valid(s_id_valid), .id_inst(s_id_inst), .id_pc(s_id_pc), .id_imm(s_id_imm),
    .id_rs1(s_id_rs1), .id_rs2(s_id_rs2), .id_rd(s_id_rd), .stall_cnt(s_stall_cnt)
  );

  function automatic bit m_hazard();
    logic [6:0] op;
    bit u1, u2;
    op = m_inst[6:0];
    u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return m_occ && ex_is_load && (ex_rd != 5'd0) &&
           ((u1 && ex_rd == m_inst[19:15]) || (u2 && ex_rd == m_inst[24:20]));
  endfunction

  function automatic bit m_valid();
    return m_occ && !m_hazard() && !ex_redirect;
  endfunction

  function automatic bit m_ready();
    return !ex_redirect && (!m_occ || (m_valid() && ex_ready));
  endfunction

  // Reference immediate computed with arithmetic shifts on the signed word
  function automatic logic [31:0] ref_imm(input logic [31:0] inst);
    logic signed [31:0] s;
    logic [31:0] sx20, sx25, sx31;
    s    = inst;
    sx20 = s >>> 20;
    sx25 = s >>> 25;
    sx31 = s >>> 31;
    case (inst[6:0])
      7'b0110011:             return 32'd0;
      7'b0110111, 7'b0010111: return inst & 32'hFFFF_F000;
      7'b0100011:             return (sx25 << 5) | 32'(inst[11:7]);
      7'b1100011:             return (sx31 << 12) | (32'(inst[7]) << 11) |
                                     (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
      7'b1101111:             return (sx31 << 20) | (32'(inst[19:12]) << 12) |
                                     (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
      default:                return sx20;
    endcase
  endfunction

  // Advance one clock and move the model by the inputs seen at that edge
  task automatic tick();
    bit hz, acc, iss;
    hz  = m_hazard();
    iss = m_valid() && ex_ready;
    acc = if_valid && m_ready();
    @(posedge clk);
    if (rst) begin
      m_occ = 0; m_inst = NOP; m_pc = RST_PC; m_cnt = 0;
    end else if (ex_redirect) begin
      m_occ = 0;
    end else if (acc) begin
      m_occ = 1; m_inst = if_inst; m_pc = if_pc;
    end else if (iss) begin
      m_occ = 0;
    end else if (hz) begin
      if (m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; if_valid = 0; if_inst = NOP; if_pc = 32'h0;
    ex_ready = 1; ex_is_load = 0; ex_rd = 5'd0; ex_redirect = 0;
  endtask

  task automatic drain();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", id_valid); else n_pass++;
    n_checks++; if (if_ready !== 1'b1) $display("FAIL reset_if_ready: got %0b want 1", if_ready); else n_pass++;
    n_checks++; if (id_inst !== NOP) $display("FAIL reset_inst: got %h want %h", id_inst, NOP); else n_pass++;
    n_checks++; if (id_pc !== RST_PC) $display("FAIL reset_pc: got %h want %h", id_pc, RST_PC); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt); else n_pass++;
    n_checks++; if (s_stall_cnt !== 3'd0) $display("FAIL reset_sat_cnt: got %0d want 0", s_stall_cnt); else n_pass++;
  endtask

  task automatic test_stream();
    idle_inputs();
    if_valid = 1; if_inst = I_ADDI; if_pc = 32'h100;
    #1;
    n_checks++; if (if_ready !== 1'b1) $display("FAIL stream_rdy0: got %0b want 1", if_ready); else n_pass++;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL stream_val0: got %0b want 0", id_valid); else n_pass++;
    tick();
    if_inst = I_SW; if_pc = 32'h104;
    #1;
    n_checks++; if (id_valid !== 1'b1) $display("FAIL stream_val1: got %0b want 1", id_valid); else n_pass++;
    n_checks++; if (if_ready !== 1'b1) $display("FAIL stream_rdy1: got %0b want 1", if_ready); else n_pass++;
    n_checks++; if (id_inst !== I_ADDI) $display("FAIL stream_inst1: got %h want %h", id_inst, I_ADDI); else n_pass++;
    n_checks++; if (id_imm !== 32'd5) $display("FAIL stream_imm1: got %h want 5", id_imm); else n_pass++;
    tick();
    if_valid = 0;
    #1;
    n_checks++; if (id_valid !== 1'b1) $display("FAIL stream_val2: got %0b want 1", id_valid); else n_pass++;
    n_checks++; if (id_inst !== I_SW) $display("FAIL stream_inst2: got %h want %h", id_inst, I_SW); else n_pass++;
    n_checks++; if (id_imm !== 32'd8) $display("FAIL stream_imm2: got %h want 8", id_imm); else n_pass++;
    n_checks++; if (id_pc !== 32'h104) $display("FAIL stream_pc2: got %h want 104", id_pc); else n_pass++;
    n_checks++; if (id_rs2 !== 5'd1 || id_rs1 !== 5'd2) $display("FAIL stream_rs: got rs1=%0d rs2=%0d want 2/1", id_rs1, id_rs2); else n_pass++;
    tick();
    #1;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL stream_empty: got %0b want 0", id_valid); else n_pass++;
    drain();
  endtask

  task automatic test_load_use();
    idle_inputs();
    if_valid = 1; if_inst = I_ADD; if_pc = 32'h200;
    tick();
    if_inst = I_ADDI; if_pc = 32'h204; ex_is_load = 1; ex_rd = 5'd1;
    #1;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL lu_bubble: got %0b want 0", id_valid); else n_pass++;
    n_checks++; if (if_ready !== 1'b0) $display("FAIL lu_if_ready: got %0b want 0", if_ready); else n_pass++;
    tick();
    ex_is_load = 0;
    #1;
    n_checks++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt: got %0d want 1", stall_cnt); else n_pass++;
    n_checks++; if (id_valid !== 1'b1) $display("FAIL lu_release: got %0b want 1", id_valid); else n_pass++;
    n_checks++; if (id_inst !== I_ADD) $display("FAIL lu_inst: got %h want %h", id_inst, I_ADD); else n_pass++;
    n_checks++; if (if_ready !== 1'b1) $display("FAIL lu_if_ready2: got %0b want 1", if_ready); else n_pass++;
    tick();
    #1;
    n_checks++; if (id_inst !== I_ADDI) $display("FAIL lu_next: got %h want %h", id_inst, I_ADDI); else n_pass++;
    drain();
  endtask

  task automatic test_no_false_hazard();
    idle_inputs();
    if_valid = 1; if_inst = I_ADD; if_pc = 32'h300;
    tick();
    if_valid = 0; ex_ready = 0; ex_is_load = 1; ex_rd = 5'd0;
    #1;
    n_checks++; if (id_valid !== 1'b1) $display("FAIL nfh_rd0: got %0b want 1", id_valid); else n_pass++;
    ex_rd = 5'd3;
    #1;
    n_checks++; if (id_valid !== 1'b1) $display("FAIL nfh_rd3: got %0b want 1", id_valid); else n_pass++;
    tick();
    ex_ready = 1; ex_rd = 5'd0; if_valid = 1; if_inst = I_LUI; if_pc = 32'h304;
    tick();
    if_valid = 0; ex_ready = 0; ex_is_load = 1; ex_rd = 5'd1;
    #1;
    n_checks++; if (id_valid !== 1'b1) $display("FAIL nfh_lui: got %0b want 1", id_valid); else n_pass++;
    n_checks++; if (id_imm !== 32'h0000_8000) $display("FAIL nfh_lui_imm: got %h want 00008000", id_imm); else n_pass++;
    tick();
    n_checks++; if (stall_cnt !== 16'd1) $display("FAIL nfh_cnt: got %0d want 1", stall_cnt); else n_pass++;
    drain();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    if_valid = 1; if_inst = I_BEQ; if_pc = 32'h400;
    tick();
    ex_ready = 0; if_inst = I_ADDI; if_pc = 32'h404;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (id_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %0b want 1", i, id_valid); else n_pass++;
      n_checks++; if (if_ready !== 1'b0) $display("FAIL bp_if_ready[%0d]: got %0b want 0", i, if_ready); else n_pass++;
      n_checks++; if (id_inst !== I_BEQ || id_pc !== 32'h400) $display("FAIL bp_hold[%0d]: got %h@%h want %h@400", i, id_inst, id_pc, I_BEQ); else n_pass++;
      n_checks++; if (id_imm !== 32'hFFFF_FFFC) $display("FAIL bp_imm[%0d]: got %h want fffffffc", i, id_imm); else n_pass++;
      tick();
    end
    ex_ready = 1;
    #1;
    n_checks++; if (if_ready !== 1'b1) $display("FAIL bp_issue: got %0b want 1", if_ready); else n_pass++;
    tick();
    n_checks++; if (id_inst !== I_ADDI) $display("FAIL bp_next: got %h want %h", id_inst, I_ADDI); else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    idle_inputs();
    if_valid = 1; if_inst = I_ADD; if_pc = 32'h500;
    tick();
    ex_redirect = 1; if_inst = I_SW; if_pc = 32'h504;
    #1;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL fl_valid: got %0b want 0", id_valid); else n_pass++;
    n_checks++; if (if_ready !== 1'b0) $display("FAIL fl_if_ready: got %0b want 0", if_ready); else n_pass++;
    tick();
    ex_redirect = 0; if_valid = 0;
    #1;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL fl_empty: got %0b want 0", id_valid); else n_pass++;
    n_checks++; if (id_inst !== I_ADD) $display("FAIL fl_dropped: got %h want %h", id_inst, I_ADD); else n_pass++;
    // redirect while stalled
    if_valid = 1; if_inst = I_ADD;
    tick();
    if_valid = 0; ex_is_load = 1; ex_rd = 5'd2;
    tick();
    ex_redirect = 1;
    #1;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL fl_stall_valid: got %0b want 0", id_valid); else n_pass++;
    tick();
    ex_redirect = 0; ex_is_load = 0;
    #1;
    n_checks++; if (stall_cnt !== 16'd2) $display("FAIL fl_stall_cnt: got %0d want 2", stall_cnt); else n_pass++;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL fl_stall_cleared: got %0b want 0", id_valid); else n_pass++;
    drain();
  endtask

  task automatic test_saturate();
    idle_inputs();
    if_valid = 1; if_inst = I_ADD;
    tick();
    if_valid = 0; ex_is_load = 1; ex_rd = 5'd1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (stall_cnt !== 16'd12) $display("FAIL sat_wide: got %0d want 12", stall_cnt); else n_pass++;
    n_checks++; if (s_stall_cnt !== 3'd7) $display("FAIL sat_narrow: got %0d want 7", s_stall_cnt); else n_pass++;
    ex_is_load = 0;
    tick();
    n_checks++; if (s_stall_cnt !== 3'd7) $display("FAIL sat_hold: got %0d want 7", s_stall_cnt); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    if_valid = 1; if_inst = I_ADD; if_pc = 32'h600;
    tick();
    ex_ready = 0; rst = 1;
    tick();
    rst = 0; if_valid = 0; ex_ready = 1;
    #1;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL rm_valid: got %0b want 0", id_valid); else n_pass++;
    n_checks++; if (id_inst !== NOP || id_pc !== RST_PC) $display("FAIL rm_regs: got %h@%h want %h@%h", id_inst, id_pc, NOP, RST_PC); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd0) $display("FAIL rm_cnt: got %0d want 0", stall_cnt); else n_pass++;
    drain();
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [31:0] inst;
    int errs;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011};
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      inst        = $urandom;
      inst[6:0]   = ops[$urandom_range(0, 8)];
      inst[19:15] = 5'($urandom_range(0, 3));
      inst[24:20] = 5'($urandom_range(0, 3));
      rst         = ($urandom_range(0, 49) == 0);
      if_valid    = ($urandom_range(0, 3) != 0);
      if_inst     = inst;
      if_pc       = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      ex_ready    = ($urandom_range(0, 3) != 0);
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 9) == 0);
      #1;
      if (!rst && errs < 20) begin
        n_checks++; if (id_valid !== m_valid()) begin errs++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, id_valid, m_valid()); end else n_pass++;
        n_checks++; if (if_ready !== m_ready()) begin errs++; $display("FAIL rnd_if_ready c%0d: got %0b want %0b", c, if_ready, m_ready()); end else n_pass++;
        n_checks++; if (id_inst !== m_inst || id_pc !== m_pc) begin errs++; $display("FAIL rnd_regs c%0d: got %h@%h want %h@%h", c, id_inst, id_pc, m_inst, m_pc); end else n_pass++;
        n_checks++; if (id_imm !== ref_imm(m_inst)) begin errs++; $display("FAIL rnd_imm c%0d: got %h want %h", c, id_imm, ref_imm(m_inst)); end else n_pass++;
        n_checks++; if (id_rd !== m_inst[11:7] || id_rs1 !== m_inst[19:15] || id_rs2 !== m_inst[24:20]) begin errs++; $display("FAIL rnd_fields c%0d: got %0d/%0d/%0d", c, id_rd, id_rs1, id_rs2); end else n_pass++;
        n_checks++; if (stall_cnt !== 16'(m_cnt)) begin errs++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, stall_cnt, m_cnt); end else n_pass++;
        n_checks++; if (s_stall_cnt !== 3'((m_cnt > 7) ? 7 : m_cnt)) begin errs++; $display("FAIL rnd_sat c%0d: got %0d want %0d", c, s_stall_cnt, (m_cnt > 7) ? 7 : m_cnt); end else n_pass++;
      end
      tick();
    end
    drain();
  endtask

  initial begin
    m_occ = 0; m_inst = NOP; m_pc = RST_PC; m_cnt = 0;
    idle_inputs();
    test_reset();
    test_stream();
    test_load_use();
    test_no_false_hazard();
    test_backpressure();
    test_flush();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
